// File: rtl/kernel_pr_fifo_pkg.sv
// Shared constants and helpers for the kernel_pr FIFO family.
package kernel_pr_fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 4;
    localparam int unsigned DEF_DEPTH      = 16;
    localparam int unsigned DEF_AF_MARGIN  = 2;
    localparam int unsigned DEF_AE_MARGIN  = 2;

    // Occupancy needs one extra bit so a completely full FIFO is representable.
    function automatic int unsigned occ_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/kernel_pr_fifo_srl_af_shiftReg.sv
// Clock-enabled shift register storage with combinational indexed read.
module kernel_pr_fifo_srl_af_shiftReg
    import kernel_pr_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  ce,
    input  logic [ADDR_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] sr [DEPTH];

    // Shift new data into entry 0 while older entries move up one slot.
    always_ff @(posedge clk) begin
        if (ce) begin
            sr[0] <= data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    // Indexed read; indices beyond DEPTH cannot occur in use but are guarded.
    always_comb begin
        q = '0;
        if (32'(a) < DEPTH) begin
            q = sr[a];
        end
    end

endmodule

// File: rtl/kernel_pr_fifo_srl_af.sv
// Shift-register FIFO with registered full/empty/almost flags and occupancy.
// Optional sticky overflow/underflow flags: define KERNEL_PR_FIFO_ERR_FLAG_EN.
module kernel_pr_fifo_srl_af
    import kernel_pr_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned AF_MARGIN  = DEF_AF_MARGIN,
    parameter int unsigned AE_MARGIN  = DEF_AE_MARGIN
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            if_din,
    input  logic                             if_write,
    input  logic                             if_write_ce,
    output logic                             if_full_n,
    output logic                             if_almost_full_n,
    input  logic                             if_read,
    input  logic                             if_read_ce,
    output logic [DATA_WIDTH-1:0]            if_dout,
    output logic                             if_empty_n,
    output logic                             if_almost_empty_n,
    output logic [occ_width(ADDR_WIDTH)-1:0] if_num_data_valid,
    output logic [occ_width(ADDR_WIDTH)-1:0] if_fifo_cap,
    output logic                             err_overflow,
    output logic                             err_underflow
);

    localparam int unsigned CW = occ_width(ADDR_WIDTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] AE_LEVEL = CW'(AE_MARGIN);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic            push;
    logic            pop;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [ADDR_WIDTH-1:0] rd_addr;

    assign push = if_write & if_write_ce & if_full_n;
    assign pop  = if_read & if_read_ce & if_empty_n;

    assign if_num_data_valid = count;
    assign if_fifo_cap       = DEPTH_C;

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + ONE;
            2'b01:   count_next = count - ONE;
            default: count_next = count;
        endcase
    end

    // Oldest entry sits at count-1 because every push shifts the line up.
    always_comb begin
        rd_addr = '0;
        if (count != '0) begin
            rd_addr = ADDR_WIDTH'(count - ONE);
        end
    end

    kernel_pr_fifo_srl_af_shiftReg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk  (clk),
        .data (if_din),
        .ce   (push),
        .a    (rd_addr),
        .q    (if_dout)
    );

    // Occupancy and status flags, all derived from the next occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            count             <= '0;
            if_empty_n        <= 1'b0;
            if_full_n         <= 1'b1;
            if_almost_empty_n <= 1'b0;
            if_almost_full_n  <= 1'b1;
        end else begin
            count             <= count_next;
            if_empty_n        <= (count_next != '0);
            if_full_n         <= (count_next != DEPTH_C);
            if_almost_empty_n <= (count_next > AE_LEVEL);
            if_almost_full_n  <= (count_next < AF_LEVEL);
        end
    end

`ifdef KERNEL_PR_FIFO_ERR_FLAG_EN
    // Sticky error flags for rejected writes and reads; cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (if_write & if_write_ce & ~if_full_n) begin
                err_overflow <= 1'b1;
            end
            if (if_read & if_read_ce & ~if_empty_n) begin
                err_underflow <= 1'b1;
            end
        end
    end
`else
    assign err_overflow  = 1'b0;
    assign err_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_kernel_pr_fifo_srl_af.sv
// Directed table-driven bench for kernel_pr_fifo_srl_af (DEPTH=4, margins 1).
module tb_kernel_pr_fifo_srl_af;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 2;
    localparam int unsigned DP = 4;

`ifdef KERNEL_PR_FIFO_ERR_FLAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic [DW-1:0] if_din;
    logic          if_write, if_write_ce;
    logic          if_full_n, if_almost_full_n;
    logic          if_read, if_read_ce;
    logic [DW-1:0] if_dout;
    logic          if_empty_n, if_almost_empty_n;
    logic [AW:0]   if_num_data_valid;
    logic [AW:0]   if_fifo_cap;
    logic          err_overflow, err_underflow;

    kernel_pr_fifo_srl_af #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DP),
        .AF_MARGIN  (1),
        .AE_MARGIN  (1)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .if_din            (if_din),
        .if_write          (if_write),
        .if_write_ce       (if_write_ce),
        .if_full_n         (if_full_n),
        .if_almost_full_n  (if_almost_full_n),
        .if_read           (if_read),
        .if_read_ce        (if_read_ce),
        .if_dout           (if_dout),
        .if_empty_n        (if_empty_n),
        .if_almost_empty_n (if_almost_empty_n),
        .if_num_data_valid (if_num_data_valid),
        .if_fifo_cap       (if_fifo_cap),
        .err_overflow      (err_overflow),
        .err_underflow     (err_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          rst;
        logic          wr;
        logic          wce;
        logic          rd;
        logic          rce;
        logic [DW-1:0] din;
        int            cnt;
        logic [DW-1:0] dout;
        logic          ovf;
        logic          unf;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t v(input logic rst, input logic wr, input logic wce,
                               input logic rd, input logic rce, input logic [DW-1:0] din,
                               input int cnt, input logic [DW-1:0] dout,
                               input logic ovf, input logic unf);
        vec_t r;
        r.rst = rst; r.wr = wr; r.wce = wce; r.rd = rd; r.rce = rce; r.din = din;
        r.cnt = cnt; r.dout = dout; r.ovf = ovf; r.unf = unf;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic wr, input logic wce,
                         input logic rd, input logic rce, input logic [DW-1:0] din);
        reset = rst; if_write = wr; if_write_ce = wce;
        if_read = rd; if_read_ce = rce; if_din = din;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input int idx, input int cnt);
        chk("num_data_valid", idx, int'(if_num_data_valid), cnt);
        chk("empty_n", idx, int'(if_empty_n), int'(cnt != 0));
        chk("full_n", idx, int'(if_full_n), int'(cnt != 4));
        chk("almost_empty_n", idx, int'(if_almost_empty_n), int'(cnt > 1));
        chk("almost_full_n", idx, int'(if_almost_full_n), int'(cnt < 3));
    endtask

    initial begin
        logic [DW-1:0] model[$];
        logic          w, r, do_push, do_pop;
        logic [DW-1:0] d;

        reset = 1'b1; if_write = 1'b0; if_write_ce = 1'b1;
        if_read = 1'b0; if_read_ce = 1'b1; if_din = '0;

        //                rst wr wce rd rce din     cnt dout   ovf unf
        tbl.push_back(v(1, 0, 1, 0, 1, 8'h00, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 1, 8'h0A, 1, 8'h0A, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 1, 8'h0B, 2, 8'h0A, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 1, 8'h0C, 3, 8'h0A, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 1, 8'h0D, 4, 8'h0A, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 1, 8'h0E, 4, 8'h0A, 1, 0));
        tbl.push_back(v(0, 0, 1, 1, 1, 8'h00, 3, 8'h0B, 1, 0));
        tbl.push_back(v(0, 0, 1, 1, 1, 8'h00, 2, 8'h0C, 1, 0));
        tbl.push_back(v(0, 0, 1, 1, 1, 8'h00, 1, 8'h0D, 1, 0));
        tbl.push_back(v(0, 0, 1, 1, 1, 8'h00, 0, 8'h00, 1, 0));
        tbl.push_back(v(0, 0, 1, 1, 1, 8'h00, 0, 8'h00, 1, 1));
        tbl.push_back(v(0, 1, 1, 0, 1, 8'h11, 1, 8'h11, 1, 1));
        tbl.push_back(v(0, 1, 1, 0, 1, 8'h22, 2, 8'h11, 1, 1));
        tbl.push_back(v(0, 1, 1, 1, 1, 8'h33, 2, 8'h22, 1, 1));
        tbl.push_back(v(0, 1, 1, 1, 1, 8'h44, 2, 8'h33, 1, 1));
        tbl.push_back(v(0, 0, 1, 1, 1, 8'h00, 1, 8'h44, 1, 1));
        tbl.push_back(v(0, 1, 1, 0, 1, 8'hA1, 2, 8'h44, 1, 1));
        tbl.push_back(v(0, 1, 1, 0, 1, 8'hA2, 3, 8'h44, 1, 1));
        tbl.push_back(v(0, 1, 1, 0, 1, 8'hA3, 4, 8'h44, 1, 1));
        tbl.push_back(v(0, 1, 1, 1, 1, 8'h55, 3, 8'hA1, 1, 1));
        tbl.push_back(v(0, 0, 1, 1, 1, 8'h00, 2, 8'hA2, 1, 1));
        tbl.push_back(v(0, 0, 1, 1, 1, 8'h00, 1, 8'hA3, 1, 1));
        tbl.push_back(v(0, 0, 1, 1, 1, 8'h00, 0, 8'h00, 1, 1));
        tbl.push_back(v(0, 1, 1, 1, 1, 8'h66, 1, 8'h66, 1, 1));
        tbl.push_back(v(0, 0, 1, 1, 1, 8'h00, 0, 8'h00, 1, 1));
        tbl.push_back(v(0, 1, 1, 0, 1, 8'h01, 1, 8'h01, 1, 1));
        tbl.push_back(v(0, 1, 1, 0, 1, 8'h02, 2, 8'h01, 1, 1));
        tbl.push_back(v(0, 1, 1, 0, 1, 8'h03, 3, 8'h01, 1, 1));
        tbl.push_back(v(1, 1, 1, 0, 1, 8'h04, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 1, 8'h77, 1, 8'h77, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 1, 8'h88, 1, 8'h77, 0, 0));
        tbl.push_back(v(0, 0, 1, 1, 0, 8'h00, 1, 8'h77, 0, 0));
        tbl.push_back(v(0, 0, 1, 1, 1, 8'h00, 0, 8'h00, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].wr, tbl[i].wce, tbl[i].rd, tbl[i].rce, tbl[i].din);
            check_state(i, tbl[i].cnt);
            if (tbl[i].cnt != 0) begin
                chk("dout", i, int'(if_dout), int'(tbl[i].dout));
            end
            chk("err_overflow", i, int'(err_overflow), int'(tbl[i].ovf & ERR_EN));
            chk("err_underflow", i, int'(err_underflow), int'(tbl[i].unf & ERR_EN));
            if (i == 0) begin
                chk("fifo_cap", i, int'(if_fifo_cap), 4);
            end
        end

        // Mixed push/pop traffic against a queue model to confirm FIFO ordering.
        for (int i = 0; i < 60; i++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = DW'($urandom_range(0, 255));
            do_pop  = r && (model.size() > 0);
            do_push = w && (model.size() < DP);
            drive(1'b0, w, 1'b1, r, 1'b1, d);
            if (do_pop) void'(model.pop_front());
            if (do_push) model.push_back(d);
            check_state(100 + i, model.size());
            if (model.size() > 0) begin
                chk("mix_dout", 100 + i, int'(if_dout), int'(model[0]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
